// File: rtl/iris_pkg.sv
// Shared types and widths for the iris-wipe transition sequencer.
// Contents: FSM state enum, transition cause codes, coordinate/radius widths,
// and the request arbitration helper (win > die > retry).
package iris_pkg;

  localparam int unsigned RADIUS_W = 10;
  localparam int unsigned X_W      = 10;
  localparam int unsigned Y_W      = 9;
  localparam int unsigned LEVEL_W  = 2;
  localparam int unsigned LIVES_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLOSING = 2'd1,
    ST_BLACK   = 2'd2,
    ST_OPENING = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_WIN   = 2'd1,
    CAUSE_DIE   = 2'd2,
    CAUSE_RETRY = 2'd3
  } cause_t;

  // Highest-priority pending request wins; NONE when nothing is asserted.
  function automatic cause_t arbitrate(input logic win, input logic die, input logic retry);
    if (win)        return CAUSE_WIN;
    else if (die)   return CAUSE_DIE;
    else if (retry) return CAUSE_RETRY;
    else            return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/iris_sequencer_if.sv
// Game-logic <-> iris sequencer signal bundle.
// slave  : the sequencer (takes frame tick, requests, player position;
//          drives iris geometry, game reset, level selection and status).
// master : the game logic / environment side.
// Optional: IRIS_LIVES_EN adds the 2-bit lives output.
interface iris_sequencer_if;
  import iris_pkg::*;

  logic                frame_tick;
  logic                req_win;
  logic                req_die;
  logic                req_retry;
  logic [X_W-1:0]      player_x;
  logic [Y_W-1:0]      player_y;
  logic [RADIUS_W-1:0] radius;
  logic [X_W-1:0]      cx;
  logic [Y_W-1:0]      cy;
  logic                mask_en;
  logic                game_rst;
  logic                level_load;
  logic [LEVEL_W-1:0]  level_id;
  logic                busy;
  logic                done;
  logic                game_over;
`ifdef IRIS_LIVES_EN
  logic [LIVES_W-1:0]  lives;
`endif

  modport slave (
`ifdef IRIS_LIVES_EN
    output lives,
`endif
    input  frame_tick, req_win, req_die, req_retry, player_x, player_y,
    output radius, cx, cy, mask_en, game_rst, level_load, level_id,
           busy, done, game_over
  );

  modport master (
`ifdef IRIS_LIVES_EN
    input  lives,
`endif
    output frame_tick, req_win, req_die, req_retry, player_x, player_y,
    input  radius, cx, cy, mask_en, game_rst, level_load, level_id,
           busy, done, game_over
  );

endinterface

// File: rtl/iris_radius_ramp.sv
// Saturating up/down iris radius register.
// Ports: clk, rst (sync, active-high); step_en/dir_up move the radius by
// RADIUS_STEP; ld_zero/ld_max force the end values (ld_zero wins).
// radius is the registered value. at_min / at_max are registered look-ahead
// flags: the next down/up step lands on 0 / MAX_RADIUS.
module iris_radius_ramp
  import iris_pkg::*;
#(
  parameter int unsigned MAX_RADIUS  = 640,
  parameter int unsigned RADIUS_STEP = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step_en,
  input  logic                dir_up,
  input  logic                ld_zero,
  input  logic                ld_max,
  output logic [RADIUS_W-1:0] radius,
  output logic                at_min,
  output logic                at_max
);

  // One spare bit so compares/adds never wrap.
  localparam int unsigned     SW     = RADIUS_W + 1;
  localparam logic [SW-1:0]   MAX_X  = SW'(MAX_RADIUS);
  localparam logic [SW-1:0]   STEP_X = SW'(RADIUS_STEP);

  logic [RADIUS_W-1:0] radius_nxt;
  logic [SW-1:0]       up_sum;
  logic [SW-1:0]       nxt_ext;

  // Saturating next value: compare before add/subtract.
  always_comb begin
    up_sum     = {1'b0, radius} + STEP_X;
    radius_nxt = radius;
    if (ld_zero) begin
      radius_nxt = '0;
    end else if (ld_max) begin
      radius_nxt = RADIUS_W'(MAX_RADIUS);
    end else if (step_en) begin
      if (dir_up) begin
        radius_nxt = (up_sum >= MAX_X) ? RADIUS_W'(MAX_RADIUS) : up_sum[RADIUS_W-1:0];
      end else begin
        radius_nxt = ({1'b0, radius} <= STEP_X) ? '0 : (radius - STEP_X[RADIUS_W-1:0]);
      end
    end
    nxt_ext = {1'b0, radius_nxt};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      radius <= '0;
      at_min <= 1'b1;
      at_max <= (STEP_X >= MAX_X);
    end else begin
      radius <= radius_nxt;
      at_min <= (nxt_ext <= STEP_X);
      at_max <= ((nxt_ext + STEP_X) >= MAX_X);
    end
  end

endmodule

// File: rtl/iris_sequencer.sv
// Iris-wipe screen transition scheduler.
// Arbitrates win/die/retry requests, sequences close -> black -> open,
// holds the game core in reset while black, selects the level to load and
// drives radius/centre/enable to the iris mask.
// Ports: clk, rst (sync, active-high); bus (iris_sequencer_if.slave).
// Optional: IRIS_LIVES_EN adds a lives counter and enables game_over.
module iris_sequencer
  import iris_pkg::*;
#(
  parameter int unsigned MAX_RADIUS   = 640,
  parameter int unsigned RADIUS_STEP  = 8,
  parameter int unsigned BLACK_FRAMES = 30,
  parameter int unsigned LEVELS       = 4,
  parameter int unsigned SPAWN_X      = 40,
  parameter int unsigned SPAWN_Y      = 400
) (
  input logic              clk,
  input logic              rst,
  iris_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = (BLACK_FRAMES > 1) ? $clog2(BLACK_FRAMES) : 1;

  state_t             state_q, state_nxt;
  cause_t             cause_q, cause_nxt;
  logic [CNT_W-1:0]   black_cnt_q, black_cnt_nxt;
  logic [X_W-1:0]     cx_q, cx_nxt;
  logic [Y_W-1:0]     cy_q, cy_nxt;
  logic [LEVEL_W-1:0] level_id_q, level_id_nxt;
  logic               level_load_q, level_load_nxt;
  logic               done_q, done_nxt;
  logic               mask_en_q, mask_en_nxt;
  logic               game_rst_q, game_rst_nxt;
  logic               busy_q, busy_nxt;
`ifdef IRIS_LIVES_EN
  logic [LIVES_W-1:0] lives_q, lives_nxt;
  logic               game_over_q, game_over_nxt;
`endif

  logic                ramp_step, ramp_up, ramp_ld_zero, ramp_ld_max;
  logic [RADIUS_W-1:0] ramp_radius;
  logic                ramp_at_min, ramp_at_max;
  logic                req_any;

  iris_radius_ramp #(
    .MAX_RADIUS  (MAX_RADIUS),
    .RADIUS_STEP (RADIUS_STEP)
  ) u_ramp (
    .clk     (clk),
    .rst     (rst),
    .step_en (ramp_step),
    .dir_up  (ramp_up),
    .ld_zero (ramp_ld_zero),
    .ld_max  (ramp_ld_max),
    .radius  (ramp_radius),
    .at_min  (ramp_at_min),
    .at_max  (ramp_at_max)
  );

  assign req_any = bus.req_win | bus.req_die | bus.req_retry;

  // Next-state and registered-output values.
  always_comb begin
    state_nxt      = state_q;
    cause_nxt      = cause_q;
    black_cnt_nxt  = black_cnt_q;
    cx_nxt         = cx_q;
    cy_nxt         = cy_q;
    level_id_nxt   = level_id_q;
    level_load_nxt = 1'b0;
    done_nxt       = 1'b0;
`ifdef IRIS_LIVES_EN
    lives_nxt      = lives_q;
    game_over_nxt  = 1'b0;
`endif
    ramp_step      = 1'b0;
    ramp_up        = 1'b0;
    ramp_ld_zero   = 1'b0;
    ramp_ld_max    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ramp_ld_max = 1'b1;
        if (req_any) begin
          cause_nxt = arbitrate(bus.req_win, bus.req_die, bus.req_retry);
          cx_nxt    = bus.player_x;
          cy_nxt    = bus.player_y;
          state_nxt = ST_CLOSING;
        end
      end
      ST_CLOSING: begin
        if (bus.frame_tick) begin
          ramp_step = 1'b1;
          if (ramp_at_min) begin
            state_nxt      = ST_BLACK;
            level_load_nxt = 1'b1;
            if (cause_q == CAUSE_WIN) begin
              level_id_nxt = (level_id_q == LEVEL_W'(LEVELS - 1)) ? '0 : (level_id_q + LEVEL_W'(1));
            end
`ifdef IRIS_LIVES_EN
            if (cause_q == CAUSE_DIE) begin
              if (lives_q == LIVES_W'(1)) begin
                lives_nxt     = LIVES_W'(3);
                level_id_nxt  = '0;
                game_over_nxt = 1'b1;
              end else begin
                lives_nxt = lives_q - LIVES_W'(1);
              end
            end
`endif
          end
        end
      end
      ST_BLACK: begin
        ramp_ld_zero = 1'b1;
        if (bus.frame_tick) begin
          if (black_cnt_q == CNT_W'(BLACK_FRAMES - 1)) begin
            black_cnt_nxt = '0;
            cx_nxt        = X_W'(SPAWN_X);
            cy_nxt        = Y_W'(SPAWN_Y);
            state_nxt     = ST_OPENING;
          end else begin
            black_cnt_nxt = black_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_OPENING: begin
        if (bus.frame_tick) begin
          ramp_step = 1'b1;
          ramp_up   = 1'b1;
          if (ramp_at_max) begin
            state_nxt = ST_IDLE;
            cause_nxt = CAUSE_NONE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = ST_BLACK;
    endcase

    mask_en_nxt  = (state_nxt != ST_IDLE);
    busy_nxt     = (state_nxt != ST_IDLE);
    game_rst_nxt = (state_nxt == ST_BLACK);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BLACK;
      cause_q      <= CAUSE_NONE;
      black_cnt_q  <= '0;
      cx_q         <= X_W'(SPAWN_X);
      cy_q         <= Y_W'(SPAWN_Y);
      level_id_q   <= '0;
      level_load_q <= 1'b0;
      done_q       <= 1'b0;
      mask_en_q    <= 1'b1;
      game_rst_q   <= 1'b1;
      busy_q       <= 1'b1;
`ifdef IRIS_LIVES_EN
      lives_q      <= LIVES_W'(3);
      game_over_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_nxt;
      cause_q      <= cause_nxt;
      black_cnt_q  <= black_cnt_nxt;
      cx_q         <= cx_nxt;
      cy_q         <= cy_nxt;
      level_id_q   <= level_id_nxt;
      level_load_q <= level_load_nxt;
      done_q       <= done_nxt;
      mask_en_q    <= mask_en_nxt;
      game_rst_q   <= game_rst_nxt;
      busy_q       <= busy_nxt;
`ifdef IRIS_LIVES_EN
      lives_q      <= lives_nxt;
      game_over_q  <= game_over_nxt;
`endif
    end
  end

  assign bus.radius     = ramp_radius;
  assign bus.cx         = cx_q;
  assign bus.cy         = cy_q;
  assign bus.mask_en    = mask_en_q;
  assign bus.game_rst   = game_rst_q;
  assign bus.level_load = level_load_q;
  assign bus.level_id   = level_id_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
`ifdef IRIS_LIVES_EN
  assign bus.lives      = lives_q;
  assign bus.game_over  = game_over_q;
`else
  assign bus.game_over  = 1'b0;
`endif

endmodule

// File: tb/tb_iris_sequencer.sv
// Directed bench for iris_sequencer (MAX_RADIUS=640, RADIUS_STEP=64,
// BLACK_FRAMES=4, LEVELS=4, spawn 40/400). Build with IRIS_LIVES_EN to
// exercise the lives counter as well.
module tb_iris_sequencer;

  localparam int MAXR  = 640;
  localparam int STEP  = 64;
  localparam int BLACK = 4;
  localparam int NTICK = 10;

  localparam int C_WIN   = 1;
  localparam int C_DIE   = 2;
  localparam int C_RETRY = 3;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   ll_cnt;
  int   level_m;
`ifdef IRIS_LIVES_EN
  int   lives_m;
`endif

  iris_sequencer_if ifc ();

  iris_sequencer #(
    .MAX_RADIUS   (MAXR),
    .RADIUS_STEP  (STEP),
    .BLACK_FRAMES (BLACK),
    .LEVELS       (4),
    .SPAWN_X      (40),
    .SPAWN_Y      (400)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts cycles with level_load high (sampled before the edge updates it).
  always @(posedge clk) if (ifc.level_load === 1'b1) ll_cnt <= ll_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic frame();
    @(negedge clk); ifc.frame_tick = 1'b1;
    @(negedge clk); ifc.frame_tick = 1'b0;
  endtask

  task automatic start_req(input bit w, input bit d, input bit r,
                           input int px, input int py, input bit with_tick);
    @(negedge clk);
    ifc.req_win = w; ifc.req_die = d; ifc.req_retry = r;
    ifc.player_x = 10'(px); ifc.player_y = 9'(py);
    ifc.frame_tick = with_tick;
    @(negedge clk);
    ifc.req_win = 0; ifc.req_die = 0; ifc.req_retry = 0; ifc.frame_tick = 0;
    chk("acc_busy", 32'(ifc.busy), 1);
    chk("acc_mask", 32'(ifc.mask_en), 1);
    chk("acc_cx", 32'(ifc.cx), 32'(px));
    chk("acc_cy", 32'(ifc.cy), 32'(py));
    chk("acc_radius", 32'(ifc.radius), MAXR);
  endtask

  task automatic close_seq(input int cause, input bit inject);
    int ll0;
    bit exp_go;
    ll0    = ll_cnt;
    exp_go = 0;
    if (cause == C_WIN) level_m = (level_m + 1) % 4;
`ifdef IRIS_LIVES_EN
    if (cause == C_DIE) begin
      if (lives_m == 1) begin lives_m = 3; level_m = 0; exp_go = 1; end
      else lives_m = lives_m - 1;
    end
`endif
    for (int i = 1; i <= NTICK; i++) begin
      if (inject && i == 5) begin
        @(negedge clk); ifc.req_retry = 1; ifc.req_win = 1;
        @(negedge clk); ifc.req_retry = 0; ifc.req_win = 0;
        chk("drop_radius", 32'(ifc.radius), 32'(MAXR - 4 * STEP));
      end
      frame();
      if (i < NTICK) begin
        chk("close_radius", 32'(ifc.radius), 32'(MAXR - i * STEP));
        chk("close_grst", 32'(ifc.game_rst), 0);
      end else begin
        chk("black_radius", 32'(ifc.radius), 0);
        chk("black_grst", 32'(ifc.game_rst), 1);
        chk("black_ll", 32'(ifc.level_load), 1);
        chk("black_level", 32'(ifc.level_id), 32'(level_m));
        chk("black_gover", 32'(ifc.game_over), 32'(exp_go));
`ifdef IRIS_LIVES_EN
        chk("black_lives", 32'(ifc.lives), 32'(lives_m));
`endif
      end
    end
    @(negedge clk);
    chk("ll_pulse_end", 32'(ifc.level_load), 0);
    chk("gover_pulse_end", 32'(ifc.game_over), 0);
    chk("ll_count", 32'(ll_cnt - ll0), 1);
  endtask

  task automatic black_seq();
    for (int i = 1; i <= BLACK; i++) begin
      frame();
      if (i < BLACK) begin
        chk("hold_grst", 32'(ifc.game_rst), 1);
      end else begin
        chk("open_grst", 32'(ifc.game_rst), 0);
        chk("open_radius0", 32'(ifc.radius), 0);
        chk("spawn_cx", 32'(ifc.cx), 40);
        chk("spawn_cy", 32'(ifc.cy), 400);
      end
    end
  endtask

  task automatic open_seq();
    for (int i = 1; i <= NTICK; i++) begin
      frame();
      chk("open_radius", 32'(ifc.radius), 32'(i * STEP));
    end
    chk("done_hi", 32'(ifc.done), 1);
    chk("idle_mask", 32'(ifc.mask_en), 0);
    chk("idle_busy", 32'(ifc.busy), 0);
    @(negedge clk);
    chk("done_lo", 32'(ifc.done), 0);
  endtask

  task automatic do_cycle(input int cause, input bit w, input bit d, input bit r,
                          input int px, input int py, input bit with_tick, input bit inject);
    start_req(w, d, r, px, py, with_tick);
    close_seq(cause, inject);
    black_seq();
    open_seq();
  endtask

  initial begin
    total = 0; bad = 0; ll_cnt = 0; level_m = 0;
`ifdef IRIS_LIVES_EN
    lives_m = 3;
`endif
    rst = 1;
    ifc.frame_tick = 0; ifc.req_win = 0; ifc.req_die = 0; ifc.req_retry = 0;
    ifc.player_x = '0; ifc.player_y = '0;
    repeat (3) @(negedge clk);
    chk("rst_radius", 32'(ifc.radius), 0);
    chk("rst_mask", 32'(ifc.mask_en), 1);
    chk("rst_grst", 32'(ifc.game_rst), 1);
    chk("rst_busy", 32'(ifc.busy), 1);
    chk("rst_level", 32'(ifc.level_id), 0);
    chk("rst_ll", 32'(ifc.level_load), 0);
    chk("rst_done", 32'(ifc.done), 0);
    chk("rst_gover", 32'(ifc.game_over), 0);
    chk("rst_cx", 32'(ifc.cx), 40);
    chk("rst_cy", 32'(ifc.cy), 400);
    rst = 0;
    black_seq();
    open_seq();

    // frame_tick alone in IDLE does nothing
    frame();
    chk("idle_tick_busy", 32'(ifc.busy), 0);
    chk("idle_tick_radius", 32'(ifc.radius), MAXR);

    // death at (200,300), request coincident with a frame tick
    do_cycle(C_DIE, 0, 1, 0, 200, 300, 1, 0);
    chk("die_level", 32'(ifc.level_id), 0);

    // win + die together resolves to win, then wrap 3 -> 0
    do_cycle(C_WIN, 1, 1, 0, 123, 45, 0, 0);
    chk("win_level1", 32'(ifc.level_id), 1);
    do_cycle(C_WIN, 1, 0, 0, 5, 6, 0, 0);
    chk("win_level2", 32'(ifc.level_id), 2);
    do_cycle(C_WIN, 1, 0, 0, 1023, 511, 0, 0);
    chk("win_level3", 32'(ifc.level_id), 3);
    do_cycle(C_WIN, 1, 0, 0, 0, 0, 0, 0);
    chk("win_wrap", 32'(ifc.level_id), 0);

    // requests during CLOSING are dropped
    do_cycle(C_DIE, 0, 1, 0, 300, 200, 0, 1);
    chk("drop_level", 32'(ifc.level_id), 32'(level_m));
    do_cycle(C_RETRY, 0, 0, 1, 77, 88, 0, 0);
    do_cycle(C_DIE, 0, 1, 1, 99, 11, 0, 0);

    // reset in mid-close
    do_cycle(C_WIN, 1, 0, 0, 400, 100, 0, 0);
    start_req(0, 1, 0, 100, 50, 0);
    for (int i = 1; i <= 5; i++) frame();
    chk("pre_rst_radius", 32'(ifc.radius), 320);
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    chk("mid_rst_radius", 32'(ifc.radius), 0);
    chk("mid_rst_grst", 32'(ifc.game_rst), 1);
    chk("mid_rst_level", 32'(ifc.level_id), 0);
    chk("mid_rst_busy", 32'(ifc.busy), 1);
    chk("mid_rst_cx", 32'(ifc.cx), 40);
    level_m = 0;
`ifdef IRIS_LIVES_EN
    lives_m = 3;
    chk("mid_rst_lives", 32'(ifc.lives), 3);
`endif
    black_seq();
    open_seq();

`ifdef IRIS_LIVES_EN
    // three deaths: 2, 1, then game over with level/lives restored
    do_cycle(C_WIN, 1, 0, 0, 10, 10, 0, 0);
    do_cycle(C_DIE, 0, 1, 0, 20, 20, 0, 0);
    chk("lives_2", 32'(ifc.lives), 2);
    do_cycle(C_DIE, 0, 1, 0, 30, 30, 0, 0);
    chk("lives_1", 32'(ifc.lives), 1);
    do_cycle(C_DIE, 0, 1, 0, 40, 40, 0, 0);
    chk("lives_reload", 32'(ifc.lives), 3);
    chk("gover_level", 32'(ifc.level_id), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iris_sequencer.md
# iris_sequencer

Scheduler for the circular iris-wipe screen transition. It arbitrates the transition requests from the game logic (win, death, retry), sequences the close → black → open cycle of the iris, and holds the game core in reset while the screen is black. It also picks the level to load, and drives radius/centre/enable into the combinational iris mask that sits in front of the VGA output.

## Interface
Parameters:
- MAX_RADIUS, 640: fully-open radius, ≤ 1023
- RADIUS_STEP, 8: radius change per frame tick, ≥ 1
- BLACK_FRAMES, 30: frame ticks held fully black, ≥ 1
- LEVELS, 4: number of levels; level_id wraps modulo LEVELS
- SPAWN_X, 40 / SPAWN_Y, 400: iris centre used while opening

Ports:
- clk  in  1  system clock (single clock; synchronous, active-high reset)
- rst  in  1  synchronous active-high reset
- frame_tick  in  1  one-clk pulse per video frame
- req_win / req_die / req_retry  in  1 each  one-clk request pulses
- player_x  in  10  player centre column
- player_y  in  9  player centre row
- radius  out  10  current iris radius
- cx  out  10 / cy  out  9  current iris centre
- mask_en  out  1  1 = apply iris mask; 0 = full brightness
- game_rst  out  1  active-high reset to game core
- level_load  out  1  one-clk pulse to load level_id
- level_id  out  2  level to load/play
- busy  out  1  high in every state except IDLE
- done  out  1  one-clk pulse when opening completes
- game_over  out  1  one-clk pulse (see Configuration)

## Operation
- States: IDLE, CLOSING, BLACK, OPENING.
- Reset values:
  - state = BLACK, black_cnt = 0, radius = 0, cx/cy = SPAWN_X/SPAWN_Y.
  - mask_en = 1, game_rst = 1, level_id = 0, level_load = 0, busy = 1, done = 0, game_over = 0.
- IDLE:
  - radius = MAX_RADIUS, mask_en = 0.
  - A request pulse latches the cause and cx/cy ← player_x/player_y, then moves to CLOSING.
  - Priority is win > die > retry; simultaneous requests resolve to the highest.
- CLOSING:
  - On each frame_tick: if radius ≤ RADIUS_STEP, radius ← 0 and go to BLACK; else radius −= RADIUS_STEP.
  - Requests are dropped in every non-IDLE state and are never queued.
- BLACK:
  - game_rst = 1.
  - On entry, level_id updates: win → (level_id+1) mod LEVELS; die/retry → unchanged.
  - level_load pulses in the first BLACK cycle, with the updated level_id.
  - black_cnt counts frame_ticks; on the BLACK_FRAMES-th tick, cx/cy ← SPAWN and go to OPENING.
- OPENING:
  - game_rst = 0.
  - On each frame_tick, radius += RADIUS_STEP, saturating at MAX_RADIUS.
  - On reaching MAX_RADIUS, go to IDLE and pulse done.
- Arithmetic: radius is 10-bit unsigned, with saturating compare before add/subtract; no wrap is permitted.

## Timing
- Request accepted at edge N → state = CLOSING, busy = 1, cx/cy latched at N+1. Radius first changes on the first frame_tick after N.
- Request and frame_tick in the same IDLE cycle: the request is accepted and radius is unchanged that cycle.
- A close or open takes ceil(MAX_RADIUS/RADIUS_STEP) frame ticks.
- level_load is registered and high exactly one clk, in the first BLACK cycle.
- done is high exactly one clk, in the first IDLE cycle.
- rst asserted in any state overrides everything at the next edge; in-flight requests are lost.
- frame_tick is ignored in IDLE.

## Configuration
- IRIS_LIVES_EN defined:
  - Adds a 2-bit lives counter, reset value 3.
  - A die-caused transition decrements lives on BLACK entry.
  - If lives was 1: lives ← 3, level_id ← 0, and game_over pulses together with level_load.
  - Also adds output port lives (out, 2).
- Undefined: no counter and no lives port; game_over is tied 0.

## Structure
- Shared package iris_pkg:
  - state enum (IDLE/CLOSING/BLACK/OPENING).
  - cause codes (NONE/WIN/DIE/RETRY).
  - width constants for radius (10), x (10) and y (9).
- Sub-module iris_radius_ramp holds the saturating up/down radius register. Inputs: step enable, direction, load-zero, load-max. Outputs: radius, at_min, at_max.
- Arbitration and the FSM stay in the top module.

## Test plan
- Reset release, with MAX_RADIUS=640, RADIUS_STEP=64, BLACK_FRAMES=4:
  - game_rst=1 for 4 ticks, then radius 64,128…640 over 10 ticks.
  - done pulses and mask_en=0.
- req_die with player_x=200, player_y=300 in IDLE: cx=200, cy=300; radius 576…0 over 10 ticks; level_load pulses with level_id=0.
- req_win and req_die in the same cycle: cause=WIN, level_id 0→1. From level_id=3 with LEVELS=4: level_id → 0.
- req_retry pulsed mid-CLOSING: radius sequence unchanged and exactly one level_load.
- rst asserted in CLOSING at radius=320: next cycle state=BLACK, radius=0, game_rst=1, level_id=0.
- IRIS_LIVES_EN, three consecutive deaths:
  - lives 2, 1, then game_over pulses on the third.
  - After the third: level_id=0, lives=3.
